// File: rtl/dis_pkg.sv
// Shared types and constants for the HDMI data-island scheduler.
// mode_t is the period type driven to the TMDS channel muxes.
package dis_pkg;

  typedef enum logic [2:0] {
    MODE_CONTROL  = 3'd0,
    MODE_PREAMBLE = 3'd1,
    MODE_LGUARD   = 3'd2,
    MODE_DATA     = 3'd3,
    MODE_TGUARD   = 3'd4
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD   = 3'd1,
    ST_PRE    = 3'd2,
    ST_LGUARD = 3'd3,
    ST_DATA   = 3'd4,
    ST_TGUARD = 3'd5
  } state_t;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PACKET_LEN   = 32;

  function automatic mode_t mode_of(input state_t st);
    case (st)
      ST_PRE:    return MODE_PREAMBLE;
      ST_LGUARD: return MODE_LGUARD;
      ST_DATA:   return MODE_DATA;
      ST_TGUARD: return MODE_TGUARD;
      default:   return MODE_CONTROL;
    endcase
  endfunction

endpackage

// File: rtl/dis_budget_check.sv
// Combinational check: does an island of n packets fit inside blank_len pixels?
// The sum is formed BLANK_W+6 bits wide so a large n can never wrap.
module dis_budget_check
  import dis_pkg::*;
#(
  parameter int BLANK_W      = 12,
  parameter int LEAD_OFFSET  = 4,
  parameter int TAIL_RESERVE = 14
) (
  input  logic [BLANK_W-1:0] blank_len,
  input  logic [4:0]         n,
  output logic               fits
);

  localparam int CW = BLANK_W + 6;
  // Lead-in, preamble, both guard bands and the tail reserve are fixed per island.
  localparam logic [CW-1:0] FIXED_COST =
    CW'(LEAD_OFFSET + PREAMBLE_LEN + 2 * GUARD_LEN + TAIL_RESERVE);

  logic [CW-1:0] need;
  logic [CW-1:0] avail;

  assign need  = FIXED_COST + (CW'(n) << 5);
  assign avail = CW'(blank_len);
  assign fits  = (need <= avail);

endmodule

// File: rtl/data_island_scheduler.sv
// Schedules HDMI data-island periods (preamble, guards, 32-pixel packets) in each
// horizontal blanking interval; all outputs are registered and describe the current pixel.
module data_island_scheduler
  import dis_pkg::*;
#(
  parameter int BLANK_W      = 12,
  parameter int LEAD_OFFSET  = 4,
  parameter int TAIL_RESERVE = 14,
  parameter int MAX_PACKETS  = 18
) (
  input  logic               clk_pixel,
  input  logic               reset_n,
  input  logic               blank_start,
  input  logic [BLANK_W-1:0] blank_len,
  input  logic               packet_request,
  output mode_t              mode,
  output logic               packet_enable,
  output logic [4:0]         packet_pixel_counter,
  output logic [4:0]         packets_in_island,
  output logic               overrun,
  output state_t             state_dbg
);

  localparam logic [BLANK_W-1:0] LEAD_RELOAD =
    (LEAD_OFFSET > 1) ? BLANK_W'(LEAD_OFFSET - 2) : '0;
  localparam logic [BLANK_W-1:0] PRE_RELOAD   = BLANK_W'(PREAMBLE_LEN - 1);
  localparam logic [BLANK_W-1:0] GUARD_RELOAD = BLANK_W'(GUARD_LEN - 1);
  localparam logic [4:0]         MAX_P        = 5'(MAX_PACKETS);

  state_t             state_q, state_d;
  logic [BLANK_W-1:0] cnt_q, cnt_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  mode_t              mode_q, mode_d;
  logic               pe_q, pe_d;
  logic [4:0]         ppc_q, ppc_d;
  logic [4:0]         pic_q, pic_d;
  logic               overrun_q, overrun_d;

  logic [BLANK_W-1:0] fit_len;
  logic [4:0]         fit_n;
  logic               fits;

  // In IDLE the check sees the incoming line's length for n=1; during DATA it
  // sees the latched length for one packet more than already issued.
  assign fit_len = (state_q == ST_IDLE) ? blank_len : blank_q;
  assign fit_n   = (state_q == ST_IDLE) ? 5'd1 : pic_q + 5'd1;

  dis_budget_check #(
    .BLANK_W      (BLANK_W),
    .LEAD_OFFSET  (LEAD_OFFSET),
    .TAIL_RESERVE (TAIL_RESERVE)
  ) u_budget (
    .blank_len (fit_len),
    .n         (fit_n),
    .fits      (fits)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    blank_d   = blank_q;
    pe_d      = 1'b0;
    ppc_d     = 5'd0;
    pic_d     = pic_q;
    overrun_d = overrun_q | (blank_start && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (blank_start) begin
          blank_d = blank_len;
          pic_d   = 5'd0;
          if (packet_request && fits) begin
            if (LEAD_OFFSET > 1) begin
              state_d = ST_LEAD;
              cnt_d   = LEAD_RELOAD;
            end else begin
              state_d = ST_PRE;
              cnt_d   = PRE_RELOAD;
            end
          end
        end
      end
      ST_LEAD: begin
        if (cnt_q == '0) begin
          state_d = ST_PRE;
          cnt_d   = PRE_RELOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PRE: begin
        if (cnt_q == '0) begin
          state_d = ST_LGUARD;
          cnt_d   = GUARD_RELOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_LGUARD: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          pic_d   = pic_q + 5'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
          pe_d  = 1'b1;
        end
      end
      ST_DATA: begin
        // The continue decision is taken one pixel early so packet_enable can be
        // registered and still appear on the counter==31 pixel; pe_q then carries it.
        if (ppc_q == 5'd30) begin
          ppc_d = 5'd31;
          pe_d  = packet_request && (pic_q < MAX_P) && fits;
        end else if (ppc_q == 5'd31) begin
          if (pe_q) begin
            pic_d = pic_q + 5'd1;
          end else begin
            state_d = ST_TGUARD;
            cnt_d   = GUARD_RELOAD;
          end
        end else begin
          ppc_d = ppc_q + 5'd1;
        end
      end
      ST_TGUARD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    mode_d = mode_of(state_d);
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      blank_q   <= '0;
      mode_q    <= MODE_CONTROL;
      pe_q      <= 1'b0;
      ppc_q     <= 5'd0;
      pic_q     <= 5'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      blank_q   <= blank_d;
      mode_q    <= mode_d;
      pe_q      <= pe_d;
      ppc_q     <= ppc_d;
      pic_q     <= pic_d;
      overrun_q <= overrun_d;
    end
  end

  assign mode                 = mode_q;
  assign packet_enable        = pe_q;
  assign packet_pixel_counter = ppc_q;
  assign packets_in_island    = pic_q;
  assign overrun              = overrun_q;
  assign state_dbg            = state_q;

endmodule

// File: tb/tb_data_island_scheduler.sv
// Directed bench for data_island_scheduler: a table of blanking lines with
// hand-computed packet counts, plus overrun and mid-island reset sequences.
module tb_data_island_scheduler;
  import dis_pkg::*;

  logic        clk_pixel = 1'b0;
  logic        reset_n;
  logic        blank_start;
  logic [11:0] blank_len;
  logic        packet_request;
  mode_t       mode;
  logic        packet_enable;
  logic [4:0]  packet_pixel_counter;
  logic [4:0]  packets_in_island;
  logic        overrun;
  state_t      state_dbg;

  data_island_scheduler #(
    .BLANK_W      (12),
    .LEAD_OFFSET  (4),
    .TAIL_RESERVE (14),
    .MAX_PACKETS  (18)
  ) dut (
    .clk_pixel            (clk_pixel),
    .reset_n              (reset_n),
    .blank_start          (blank_start),
    .blank_len            (blank_len),
    .packet_request       (packet_request),
    .mode                 (mode),
    .packet_enable        (packet_enable),
    .packet_pixel_counter (packet_pixel_counter),
    .packets_in_island    (packets_in_island),
    .overrun              (overrun),
    .state_dbg            (state_dbg)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    logic [11:0] blen;
    int          drop_p;   // request is high for p < drop_p
    int          exp_n;    // packets expected in the island
    int          exp_tg;   // first TGUARD pixel, -1 when no island
  } vec_t;

  localparam int NEVER = 100000;

  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;
  int   prev_n = 0;
  logic exp_ovr = 1'b0;

  task automatic check(input string name, input int p, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s p=%0d: got %0d expected %0d", name, p, act, exp);
    end
  endtask

  // Expected timeline for an island of n packets with a 4-pixel lead-in.
  function automatic int exp_mode(input int p, input int n);
    if (n == 0)             return 0;
    if (p < 4)              return 0;
    if (p < 12)             return 1;
    if (p < 14)             return 2;
    if (p < 14 + 32 * n)    return 3;
    if (p < 16 + 32 * n)    return 4;
    return 0;
  endfunction

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk_pixel); #1;
      blank_start = 1'b0;
    end
  endtask

  task automatic run_line(input logic [11:0] blen, input int drop_p, input int n,
                          input int restart_p, input int cycles, output int tg_seen);
    int e_pe, e_ppc, e_pic;
    tg_seen = -1;
    for (int p = 0; p < cycles; p++) begin
      @(posedge clk_pixel); #1;
      blank_start    = (p == 0) || (p == restart_p);
      blank_len      = blen;
      packet_request = (p < drop_p);
      @(negedge clk_pixel);
      if (restart_p > 0 && p > restart_p) exp_ovr = 1'b1;
      e_pe  = (n > 0 && p >= 13 && p < 13 + 32 * n && ((p - 13) % 32) == 0) ? 1 : 0;
      e_ppc = (exp_mode(p, n) == 3) ? (p - 14) % 32 : 0;
      if (p == 0)                 e_pic = prev_n;
      else if (n == 0 || p < 14)  e_pic = 0;
      else                        e_pic = ((p - 14) / 32 + 1 < n) ? (p - 14) / 32 + 1 : n;
      check("mode", p, int'(mode), exp_mode(p, n));
      check("packet_enable", p, int'(packet_enable), e_pe);
      check("pixel_counter", p, int'(packet_pixel_counter), e_ppc);
      check("packets_in_island", p, int'(packets_in_island), e_pic);
      check("overrun", p, int'(overrun), int'(exp_ovr));
      if (mode == MODE_TGUARD && tg_seen < 0) tg_seen = p;
    end
    blank_start = 1'b0;
    prev_n = n;
  endtask

  initial begin
    int tg;
    vecs[0] = '{12'd61,   NEVER, 0,  -1};
    vecs[1] = '{12'd62,   NEVER, 1,  46};
    vecs[2] = '{12'd160,  NEVER, 4,  142};
    vecs[3] = '{12'd4000, NEVER, 18, 590};
    vecs[4] = '{12'd160,  50,    2,  78};
    vecs[5] = '{12'd0,    NEVER, 0,  -1};
    vecs[6] = '{12'd160,  0,     0,  -1};
    vecs[7] = '{12'd93,   NEVER, 1,  46};
    vecs[8] = '{12'd94,   NEVER, 2,  78};

    reset_n        = 1'b0;
    blank_start    = 1'b0;
    blank_len      = 12'd0;
    packet_request = 1'b0;
    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    check("reset_mode", 0, int'(mode), 0);
    check("reset_packet_enable", 0, int'(packet_enable), 0);
    check("reset_pixel_counter", 0, int'(packet_pixel_counter), 0);
    check("reset_packets_in_island", 0, int'(packets_in_island), 0);
    check("reset_overrun", 0, int'(overrun), 0);
    check("reset_state", 0, int'(state_dbg), int'(ST_IDLE));
    @(posedge clk_pixel); #1;
    reset_n = 1'b1;
    idle(3);

    for (int v = 0; v < 9; v++) begin
      run_line(vecs[v].blen, vecs[v].drop_p, vecs[v].exp_n, -1,
               (vecs[v].exp_n == 0) ? 70 : 16 + 32 * vecs[v].exp_n + 6, tg);
      check("tguard_start", v, tg, vecs[v].exp_tg);
      idle(4);
    end

    // Second blank_start mid-island: island completes, overrun becomes sticky.
    run_line(12'd62, NEVER, 1, 30, 56, tg);
    check("overrun_tguard_start", 30, tg, 46);
    check("overrun_sticky", 56, int'(overrun), 1);
    idle(4);

    // Reset mid-island at p=20: outputs return to reset values at once.
    run_line(12'd160, NEVER, 4, -1, 20, tg);
    @(posedge clk_pixel); #1;
    reset_n = 1'b0;
    #1;
    check("midreset_mode", 20, int'(mode), 0);
    check("midreset_pixel_counter", 20, int'(packet_pixel_counter), 0);
    check("midreset_packet_enable", 20, int'(packet_enable), 0);
    check("midreset_packets_in_island", 20, int'(packets_in_island), 0);
    check("midreset_overrun", 20, int'(overrun), 0);
    check("midreset_state", 20, int'(state_dbg), int'(ST_IDLE));
    idle(2);
    reset_n = 1'b1;
    exp_ovr = 1'b0;
    prev_n  = 0;
    idle(3);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_pixel);
      check("post_reset_mode", i, int'(mode), 0);
    end

    // Next line after the reset runs clean.
    run_line(12'd62, NEVER, 1, -1, 54, tg);
    check("post_reset_tguard_start", 0, tg, 46);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
